// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a word-addressed data memory
module load_store_unit #(
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_Addr,
  output logic [31:0]       o_mem_Wd,
  output logic [3:0]        o_mem_Wen,
  output logic              o_mem_Ren,
  input  logic [31:0]       i_mem_Rd
);
  typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;
  localparam logic [2:0] LAT = 3'(MEM_RD_LAT);
  state_t state, state_d;
  logic [2:0] cnt, cnt_d, f3;
  logic [1:0] lo;
  logic accept, mis, ill, err_in, last;
  logic [3:0] wen_in;
  logic [31:0] wd_in, ext;
  logic [15:0] half;
  logic [7:0] byte_v;
  logic ready_d, rv_d, err_d, ren_d;
  logic [31:0] rdata_d, wd_d;
  logic [3:0] wen_d;
  logic [ADDR_W-1:0] addr_d;
  assign accept = i_req_valid & o_req_ready;
  assign mis = ((i_req_funct3[1:0] == 2'b01) & i_req_addr[0]) |
               ((i_req_funct3[1:0] == 2'b10) & (|i_req_addr[1:0]));
  assign ill = i_req_we ? (i_req_funct3[2] | (&i_req_funct3[1:0]))
                        : ((&i_req_funct3[1:0]) | (&i_req_funct3[2:1]));
  assign err_in = mis | ill;
  assign wen_in = i_req_funct3[1:0] == 2'b00 ? 4'b0001 << i_req_addr[1:0] :
                  i_req_funct3[1:0] == 2'b01 ? 4'b0011 << {i_req_addr[1], 1'b0} : 4'b1111;
  assign wd_in = i_req_funct3[1:0] == 2'b00 ? {4{i_req_wdata[7:0]}} :
                 i_req_funct3[1:0] == 2'b01 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
  assign last = cnt == LAT;
  assign half = lo[1] ? i_mem_Rd[31:16] : i_mem_Rd[15:0];
  assign byte_v = lo[0] ? half[15:8] : half[7:0];
  assign ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & byte_v[7]}}, byte_v} :
               f3[1:0] == 2'b01 ? {{16{~f3[2] & half[15]}}, half} : i_mem_Rd;
  // state, latched request lane info and all registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      lo <= '0;
      o_req_ready <= 1'b0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err <= 1'b0;
      o_mem_Addr <= '0;
      o_mem_Wd <= '0;
      o_mem_Wen <= '0;
      o_mem_Ren <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        f3 <= i_req_funct3;
        lo <= i_req_addr[1:0];
      end
      o_req_ready <= ready_d;
      o_resp_valid <= rv_d;
      o_resp_rdata <= rdata_d;
      o_resp_err <= err_d;
      o_mem_Addr <= addr_d;
      o_mem_Wd <= wd_d;
      o_mem_Wen <= wen_d;
      o_mem_Ren <= ren_d;
    end
  end
  // next state: errors skip the memory phase entirely
  always_comb
    state_d = state == IDLE  ? (accept ? (err_in ? RESP : i_req_we ? STORE : LOAD) : IDLE) :
              state == STORE ? RESP :
              state == LOAD  ? (last ? RESP : LOAD) :
              (i_resp_ready ? IDLE : RESP);
  // next values of the registered outputs; Addr and the response hold unless updated
  always_comb begin
    ready_d = 1'b0;
    rv_d = o_resp_valid;
    rdata_d = o_resp_rdata;
    err_d = o_resp_err;
    addr_d = o_mem_Addr;
    wd_d = '0;
    wen_d = '0;
    ren_d = 1'b0;
    cnt_d = cnt;
    case (state)
      IDLE: begin
        ready_d = ~accept;
        if (accept) begin
          addr_d = err_in ? o_mem_Addr : {i_req_addr[ADDR_W-1:2], 2'b00};
          wen_d = (i_req_we & ~err_in) ? wen_in : 4'b0000;
          wd_d = (i_req_we & ~err_in) ? wd_in : 32'd0;
          ren_d = ~i_req_we & ~err_in;
          cnt_d = '0;
          rv_d = err_in;
          err_d = err_in;
          rdata_d = '0;
        end
      end
      STORE: begin
        rv_d = 1'b1;
        err_d = 1'b0;
        rdata_d = '0;
      end
      LOAD: begin
        ren_d = ~last;
        cnt_d = cnt + 3'd1;
        rv_d = last;
        rdata_d = last ? ext : 32'd0;
        err_d = 1'b0;
      end
      default: begin
        ready_d = i_resp_ready;
        rv_d = ~i_resp_ready;
        rdata_d = i_resp_ready ? 32'd0 : o_resp_rdata;
        err_d = ~i_resp_ready & o_resp_err;
      end
    endcase
  end
endmodule
